complex_to_pixel: RTL and testbench

- Inverse of the pixel-to-complex mapper: converts a complex point (Q4.28) into screen pixel coordinates (x, y) under the current zoom and center.
- Used for orbit and cursor overlays and for re-projecting points after a pan or zoom.
- Sequential: valid/ready handshake on input and output, with an 11-cycle serial divider per axis.

---
 rtl/mandel_pkg.sv | 31 +++
 rtl/serial_udiv.sv | 67 ++++++
 rtl/complex_to_pixel.sv | 151 +++++++++++++++
 tb/tb_complex_to_pixel.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// ============================================================================
// Module  : mandel_pkg
// Brief   : Shared fractal-viewer types and constants for complex/pixel mappers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mandel_pkg;

  localparam int WORD_LENGTH = 32;
  localparam int FRAC        = 28;
  localparam int PIX_W       = 11;
  localparam int NUM_W       = 41;

  typedef logic signed [WORD_LENGTH-1:0] coord_t;
  typedef logic [PIX_W-1:0]              pix_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } c2p_state_t;

  function automatic pix_t clamp_pix(input pix_t q, input pix_t lim);
    return (q > lim) ? lim : q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_udiv.sv
// ============================================================================
// Module  : serial_udiv
// Brief   : Restoring unsigned divider, one quotient bit per cycle, MSB first.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_udiv #(
  parameter int NUM_W = 41,
  parameter int DIV_W = 32,
  parameter int Q_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NUM_W-1:0] numerator,
  input  logic [DIV_W-1:0] divisor,
  output logic [Q_W-1:0]   quotient,
  output logic             done
);

  localparam int SH_W  = DIV_W + Q_W - 1;
  localparam int CMP_W = (NUM_W > SH_W) ? NUM_W : SH_W;
  localparam int CNT_W = $clog2(Q_W);

  logic [NUM_W-1:0] rem;
  logic [CMP_W-1:0] dsh;
  logic [Q_W-1:0]   q;
  logic [CNT_W-1:0] cnt;
  logic             running;

  logic             w_ge;
  logic [NUM_W-1:0] w_diff;

  // dsh holds divisor << (remaining bit index); quotient < 2^Q_W keeps rem in range
  assign w_ge   = CMP_W'(rem) >= dsh;
  assign w_diff = rem - dsh[NUM_W-1:0];

  // done flags the cycle in which the final quotient bit is being resolved
  assign done     = running && (cnt == CNT_W'(Q_W - 1));
  assign quotient = q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      dsh     <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      rem     <= numerator;
      dsh     <= CMP_W'(divisor) << (Q_W - 1);
      q       <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (w_ge) rem <= w_diff;
      q   <= {q[Q_W-2:0], w_ge};
      dsh <= dsh >> 1;
      cnt <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/complex_to_pixel.sv
// ============================================================================
// Module  : complex_to_pixel
// Brief   : Maps a Q4.28 complex point to screen (x, y) under zoom and center.
//           Define ROUND_NEAREST_EN for round-half-up results clamped to screen.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module complex_to_pixel #(
  parameter int WORD_LENGTH   = mandel_pkg::WORD_LENGTH,
  parameter int FRAC          = mandel_pkg::FRAC,
  parameter int SCREEN_WIDTH  = 960,
  parameter int SCREEN_HEIGHT = 720
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [31:0]            ZOOM,
  input  logic signed [WORD_LENGTH-1:0] real_center,
  input  logic signed [WORD_LENGTH-1:0] imag_center,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [WORD_LENGTH-1:0] real_in,
  input  logic signed [WORD_LENGTH-1:0] imag_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [10:0]                   x,
  output logic [10:0]                   y,
  output logic                          out_of_range,
  output logic                          busy
);

  import mandel_pkg::*;

  localparam logic signed [WORD_LENGTH-1:0] ONE     = WORD_LENGTH'(1) << FRAC;
  localparam logic signed [WORD_LENGTH-1:0] SPAN_RE = 3 * ONE;
  localparam logic signed [WORD_LENGTH-1:0] SPAN_IM = 2 * ONE;

  c2p_state_t                    state;
  logic signed [31:0]            zoom_r;
  logic signed [WORD_LENGTH-1:0] real_center_r, imag_center_r;
  logic signed [WORD_LENGTH-1:0] real_in_r, imag_in_r;
  logic                          oor_r;

  logic signed [WORD_LENGTH-1:0] real_width, imag_height;
  logic signed [WORD_LENGTH-1:0] real_min, imag_max;
  logic signed [WORD_LENGTH:0]   dx, dy, rw_ext, ih_ext;
  logic                          range_err;
  logic [NUM_W-1:0]              num_x, num_y;
  logic [PIX_W-1:0]              qx, qy;
  logic                          x_done, y_done;
  logic                          div_start;

  // Window geometry mirrors the forward mapper, including 32-bit wraparound
  assign real_width  = SPAN_RE >>> zoom_r;
  assign imag_height = SPAN_IM >>> zoom_r;
  assign real_min    = real_center_r - (real_width >>> 1);
  assign imag_max    = imag_center_r + (imag_height >>> 1);

  assign dx     = {real_in_r[WORD_LENGTH-1], real_in_r} - {real_min[WORD_LENGTH-1], real_min};
  assign dy     = {imag_max[WORD_LENGTH-1], imag_max} - {imag_in_r[WORD_LENGTH-1], imag_in_r};
  assign rw_ext = {1'b0, real_width};
  assign ih_ext = {1'b0, imag_height};

  assign range_err = dx[WORD_LENGTH] | (dx >= rw_ext) | dy[WORD_LENGTH] | (dy >= ih_ext) |
                     (real_width == '0) | (imag_height == '0);

`ifdef ROUND_NEAREST_EN
  assign num_x = NUM_W'(dx[WORD_LENGTH-1:0]) * NUM_W'(SCREEN_WIDTH)
               + NUM_W'(real_width[WORD_LENGTH-1:1]);
  assign num_y = NUM_W'(dy[WORD_LENGTH-1:0]) * NUM_W'(SCREEN_HEIGHT)
               + NUM_W'(imag_height[WORD_LENGTH-1:1]);
`else
  assign num_x = NUM_W'(dx[WORD_LENGTH-1:0]) * NUM_W'(SCREEN_WIDTH);
  assign num_y = NUM_W'(dy[WORD_LENGTH-1:0]) * NUM_W'(SCREEN_HEIGHT);
`endif

  // The dividers latch numerator and divisor at the end of SETUP
  assign div_start = (state == SETUP) && !range_err;

  serial_udiv #(.NUM_W(NUM_W), .DIV_W(WORD_LENGTH), .Q_W(PIX_W)) u_div_x (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .numerator (num_x),
    .divisor   (real_width),
    .quotient  (qx),
    .done      (x_done)
  );

  serial_udiv #(.NUM_W(NUM_W), .DIV_W(WORD_LENGTH), .Q_W(PIX_W)) u_div_y (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .numerator (num_y),
    .divisor   (imag_height),
    .quotient  (qy),
    .done      (y_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      zoom_r        <= '0;
      real_center_r <= '0;
      imag_center_r <= '0;
      real_in_r     <= '0;
      imag_in_r     <= '0;
      oor_r         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            zoom_r        <= ZOOM;
            real_center_r <= real_center;
            imag_center_r <= imag_center;
            real_in_r     <= real_in;
            imag_in_r     <= imag_in;
            state         <= SETUP;
          end
        end
        SETUP: begin
          oor_r <= range_err;
          state <= range_err ? DONE : DIVIDE;
        end
        DIVIDE: begin
          if (x_done && y_done) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign busy         = (state != IDLE);
  assign out_valid    = (state == DONE);
  assign out_of_range = out_valid & oor_r;

`ifdef ROUND_NEAREST_EN
  assign x = (out_valid && !oor_r) ? clamp_pix(qx, PIX_W'(SCREEN_WIDTH - 1))  : '0;
  assign y = (out_valid && !oor_r) ? clamp_pix(qy, PIX_W'(SCREEN_HEIGHT - 1)) : '0;
`else
  assign x = (out_valid && !oor_r) ? qx : '0;
  assign y = (out_valid && !oor_r) ? qy : '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_complex_to_pixel.sv
// ============================================================================
// Module  : tb_complex_to_pixel
// Brief   : Self-checking bench for complex_to_pixel against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_complex_to_pixel;

  localparam int SW = 960;
  localparam int SH = 720;
  localparam int ONE = 268435456;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [31:0] ZOOM;
  logic signed [31:0] real_center, imag_center, real_in, imag_in;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [10:0]        x, y;
  logic               out_of_range, busy;

  int  vectors = 0;
  int  errors  = 0;
  time accept_t;

  always #5 clk = ~clk;

  complex_to_pixel dut (
    .clk          (clk),
    .reset        (reset),
    .ZOOM         (ZOOM),
    .real_center  (real_center),
    .imag_center  (imag_center),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .real_in      (real_in),
    .imag_in      (imag_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .x            (x),
    .y            (y),
    .out_of_range (out_of_range),
    .busy         (busy)
  );

  // Reference: window geometry and pixel division done with wide integer arithmetic
  function automatic void model(input int zoom, input int rc, input int ic, input int re,
                                input int im, output int mx, output int my, output bit moor);
    int     rw, ih, rmin, imax;
    longint dx, dy;
    rw   = (zoom < 0 || zoom >= 32) ? 0 : (3 * ONE) / (1 << zoom);
    ih   = (zoom < 0 || zoom >= 32) ? 0 : (2 * ONE) / (1 << zoom);
    rmin = rc - rw / 2;
    imax = ic + ih / 2;
    dx   = longint'(re) - longint'(rmin);
    dy   = longint'(imax) - longint'(im);
    moor = (dx < 0) || (dx >= rw) || (dy < 0) || (dy >= ih) || (rw == 0) || (ih == 0);
    mx = 0;
    my = 0;
    if (!moor) begin
`ifdef ROUND_NEAREST_EN
      mx = int'((dx * SW + rw / 2) / rw);
      my = int'((dy * SH + ih / 2) / ih);
      if (mx > SW - 1) mx = SW - 1;
      if (my > SH - 1) my = SH - 1;
`else
      mx = int'((dx * SW) / rw);
      my = int'((dy * SH) / ih);
`endif
    end
  endfunction

  // Drives one point, waits for the result; lat counts edges from acceptance inclusive
  task automatic drive_point(input int zoom, input int rc, input int ic, input int re,
                             input int im, output int ox, output int oy, output bit ooor,
                             output int lat, output bit ok);
    int n;
    ok = 1'b1;
    ZOOM = zoom; real_center = rc; imag_center = ic; real_in = re; imag_in = im;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) ok = 1'b0;
    @(posedge clk);
    accept_t = $time;
    #1 in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) ok = 1'b0;
    ox = int'(x); oy = int'(y); ooor = out_of_range;
    if (out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    ZOOM = 0; real_center = 0; imag_center = 0; real_in = 0; imag_in = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || x !== 11'd0 ||
        y !== 11'd0 || out_of_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b x=%0d y=%0d oor=%b, required 1 0 0 0 0 0",
               in_ready, out_valid, busy, x, y, out_of_range);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic test_corners();
    int ox, oy, lat, mx, my;
    bit oor, mo, ok;
    drive_point(0, 0, 0, -402653184, 268435455, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || ox != 0 || oy != 0 || oor || lat != 13) begin
      errors++;
      $display("FAIL corner_min: x=%0d y=%0d oor=%b lat=%0d, required 0 0 0 13", ox, oy, oor, lat);
    end
    drive_point(0, 0, 0, 0, 0, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || ox != 480 || oy != 360 || oor) begin
      errors++;
      $display("FAIL center_point: x=%0d y=%0d oor=%b, required 480 360 0", ox, oy, oor);
    end
    drive_point(0, 0, 0, 402653184, 0, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || ox != 0 || oy != 0 || !oor || lat != 2) begin
      errors++;
      $display("FAIL right_edge_oor: x=%0d y=%0d oor=%b lat=%0d, required 0 0 1 2", ox, oy, oor, lat);
    end
    drive_point(0, 0, 0, 402653183, -268435455, ox, oy, oor, lat, ok);
    model(0, 0, 0, 402653183, -268435455, mx, my, mo);
    vectors++;
    if (!ok || ox != mx || oy != my || oor != mo) begin
      errors++;
      $display("FAIL last_in_range: x=%0d y=%0d oor=%b, required %0d %0d %b", ox, oy, oor, mx, my, mo);
    end
    drive_point(0, 0, 0, 0, -268435456, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || !oor || ox != 0 || oy != 0) begin
      errors++;
      $display("FAIL bottom_edge_oor: x=%0d y=%0d oor=%b, required 0 0 1", ox, oy, oor);
    end
    drive_point(30, 0, 0, 0, 0, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || !oor || ox != 0 || oy != 0) begin
      errors++;
      $display("FAIL zoom30_oor: x=%0d y=%0d oor=%b, required 0 0 1", ox, oy, oor);
    end
  endtask

  task automatic test_stall();
    int ox, oy, lat, sx, sy;
    bit oor, ok;
    out_ready = 1'b0;
    drive_point(0, 0, 0, 100000000, -50000000, ox, oy, oor, lat, ok);
    sx = ox; sy = oy;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || int'(x) != sx || int'(y) != sy) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out_valid=%b in_ready=%b x=%0d y=%0d, required 1 0 %0d %0d",
                 i, out_valid, in_ready, x, y, sx, sy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_random();
    int  ox, oy, lat, mx, my, zoom, rc, ic, re, im, rw, ih;
    bit  oor, mo, ok;
    int  bad = 0;
    for (int i = 0; i < 150; i++) begin
      zoom = int'($urandom_range(0, 6));
      rc   = int'($urandom_range(0, 2 * ONE)) - ONE;
      ic   = int'($urandom_range(0, 2 * ONE)) - ONE;
      rw   = (3 * ONE) / (1 << zoom);
      ih   = (2 * ONE) / (1 << zoom);
      re   = int'(longint'(rc) + longint'($urandom_range(0, rw / 4 * 5)) - longint'(rw / 8 * 5));
      im   = int'(longint'(ic) + longint'($urandom_range(0, ih / 4 * 5)) - longint'(ih / 8 * 5));
      drive_point(zoom, rc, ic, re, im, ox, oy, oor, lat, ok);
      model(zoom, rc, ic, re, im, mx, my, mo);
      vectors++;
      if (!ok || ox != mx || oy != my || oor != mo || lat != (mo ? 2 : 13)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random[%0d]: x=%0d y=%0d oor=%b lat=%0d, required %0d %0d %b %0d",
                   i, ox, oy, oor, lat, mx, my, mo, mo ? 2 : 13);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int  ox, oy, lat;
    bit  oor, ok;
    time t0;
    drive_point(2, 0, 0, 1000, 2000, ox, oy, oor, lat, ok);
    t0 = accept_t;
    drive_point(2, 0, 0, -3000, 4000, ox, oy, oor, lat, ok);
    vectors++;
    if (!ok || (accept_t - t0) != 140) begin
      errors++;
      $display("FAIL back_to_back: accept spacing=%0t, required 140", accept_t - t0);
    end
  endtask

  task automatic test_round_trip();
    int ox, oy, lat, px, py, re, im, rc, ic, rw, ih, dxe, dye;
    bit oor, ok;
    int bad = 0;
    rc = -134217728;
    ic = 26843546;
    rw = (3 * ONE) / 16;
    ih = (2 * ONE) / 16;
    for (int i = 0; i < SW; i++) begin
      px = i;
      py = (i * 7) % SH;
      re = (rc - rw / 2) + int'((longint'(px) * rw) / SW);
      im = (ic + ih / 2) - int'((longint'(py) * ih) / SH);
      drive_point(4, rc, ic, re, im, ox, oy, oor, lat, ok);
      dxe = px - ox;
      dye = py - oy;
      vectors++;
`ifdef ROUND_NEAREST_EN
      if (!ok || oor || dxe != 0 || dye != 0) begin
`else
      if (!ok || oor || dxe < 0 || dxe > 1 || dye < 0 || dye > 1) begin
`endif
        errors++;
        if (bad < 10)
          $display("FAIL round_trip[%0d]: x=%0d y=%0d oor=%b, required near %0d %0d 0",
                   i, ox, oy, oor, px, py);
        bad++;
      end
    end
  endtask

  task automatic test_reset_abort();
    int ox, oy, lat, mx, my, vis;
    bit oor, mo, ok;
    ZOOM = 0; real_center = 0; imag_center = 0; real_in = 0; imag_in = 0;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: busy=%b in_ready=%b, required 0 1", busy, in_ready);
    end
    vis = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) vis++;
    end
    vectors++;
    if (vis != 0) begin
      errors++;
      $display("FAIL abort_no_output: out_valid cycles=%0d, required 0", vis);
    end
    drive_point(1, 5000000, -7000000, 12345678, 23456789, ox, oy, oor, lat, ok);
    model(1, 5000000, -7000000, 12345678, 23456789, mx, my, mo);
    vectors++;
    if (!ok || ox != mx || oy != my || oor != mo) begin
      errors++;
      $display("FAIL after_abort: x=%0d y=%0d oor=%b, required %0d %0d %b", ox, oy, oor, mx, my, mo);
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_stall();
    test_random();
    test_back_to_back();
    test_round_trip();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
